// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-stage hold/bubble enables, exception redirect, stall-cycle counter.
// Latency: stall/flush/redirect are combinational (same cycle); counter updates on the next clk_i edge.
// Backpressure: the latest requesting stage wins; an exception waits in WAIT_MEM until MEM drops its stall.
module pipeline_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_stall_req_i,
    input  logic        id_stall_req_i,
    input  logic        ex_stall_req_i,
    input  logic        mem_stall_req_i,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_target_i,
    input  logic        perf_clr_i,
    output logic [4:0]  stall_o,
    output logic [4:0]  flush_o,
    output logic        new_pc_valid_o,
    output logic [31:0] new_pc_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [4:0] STALL_MEM = 5'b01111;
    localparam logic [4:0] FLUSH_MEM = 5'b10000;
    localparam logic [4:0] STALL_EX  = 5'b00111;
    localparam logic [4:0] FLUSH_EX  = 5'b01000;
    localparam logic [4:0] STALL_ID  = 5'b00011;
    localparam logic [4:0] FLUSH_ID  = 5'b00100;
    localparam logic [4:0] STALL_IF  = 5'b00001;
    localparam logic [4:0] FLUSH_IF  = 5'b00010;
    localparam logic [4:0] FLUSH_EXC = 5'b11110;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] exc_tgt_q;
    logic        exc_defer;

    // An exception behind a stalled MEM cannot redirect yet; park its target.
    assign exc_defer = (state_q == RUN) && exc_valid_i && mem_stall_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (exc_defer) state_d = WAIT_MEM;
            WAIT_MEM: if (!mem_stall_req_i) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        stall_o        = 5'b00000;
        flush_o        = 5'b00000;
        new_pc_valid_o = 1'b0;
        new_pc_o       = 32'h0;
        if (!rst_i) begin
            case (state_q)
                RUN: begin
                    if (exc_valid_i && !mem_stall_req_i) begin
                        flush_o        = FLUSH_EXC;
                        new_pc_valid_o = 1'b1;
                        new_pc_o       = exc_target_i;
                    end else if (mem_stall_req_i) begin
                        stall_o = STALL_MEM;
                        flush_o = FLUSH_MEM;
                    end else if (ex_stall_req_i) begin
                        stall_o = STALL_EX;
                        flush_o = FLUSH_EX;
                    end else if (id_stall_req_i) begin
                        stall_o = STALL_ID;
                        flush_o = FLUSH_ID;
                    end else if (if_stall_req_i) begin
                        stall_o = STALL_IF;
                        flush_o = FLUSH_IF;
                    end
                end
                WAIT_MEM: begin
                    if (mem_stall_req_i) begin
                        stall_o = STALL_MEM;
                        flush_o = FLUSH_MEM;
                    end else begin
                        flush_o        = FLUSH_EXC;
                        new_pc_valid_o = 1'b1;
                        new_pc_o       = exc_tgt_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exc_tgt_q <= 32'h0;
        end else if (exc_defer) begin
            exc_tgt_q <= exc_target_i;
        end
    end

    // Clear beats increment; count sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= 16'h0;
        end else if (perf_clr_i) begin
            stall_cnt_o <= 16'h0;
        end else if (stall_o[0] && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'h1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a behavioural model of its stall, exception and counter rules.
module tb_pipeline_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_stall_req_i, id_stall_req_i, ex_stall_req_i, mem_stall_req_i;
    logic        exc_valid_i;
    logic [31:0] exc_target_i;
    logic        perf_clr_i;
    logic [4:0]  stall_o, flush_o;
    logic        new_pc_valid_o;
    logic [31:0] new_pc_o;
    logic [15:0] stall_cnt_o;

    pipeline_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .if_stall_req_i (if_stall_req_i),
        .id_stall_req_i (id_stall_req_i),
        .ex_stall_req_i (ex_stall_req_i),
        .mem_stall_req_i(mem_stall_req_i),
        .exc_valid_i    (exc_valid_i),
        .exc_target_i   (exc_target_i),
        .perf_clr_i     (perf_clr_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_valid_o (new_pc_valid_o),
        .new_pc_o       (new_pc_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model: a pending exception (with its target) and an integer stall count.
    bit          m_pend = 1'b0;
    logic [31:0] m_tgt  = 32'h0;
    int          m_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stage ranks: MEM=4, EX=3, ID=2, IF=1. Stalling rank k holds every register below k and bubbles register k.
    task automatic model_outs(output logic [4:0] es, output logic [4:0] ef,
                              output logic ev, output logic [31:0] ep);
        int k;
        es = '0; ef = '0; ev = 1'b0; ep = '0;
        if (rst_i) return;
        if (m_pend) begin
            if (mem_stall_req_i) begin
                es = 5'((1 << 4) - 1); ef = 5'(1 << 4);
            end else begin
                ef = 5'b11110; ev = 1'b1; ep = m_tgt;
            end
        end else if (exc_valid_i && !mem_stall_req_i) begin
            ef = 5'b11110; ev = 1'b1; ep = exc_target_i;
        end else begin
            k = mem_stall_req_i ? 4 : ex_stall_req_i ? 3 : id_stall_req_i ? 2 : if_stall_req_i ? 1 : 0;
            if (k > 0) begin
                es = 5'((1 << k) - 1);
                ef = 5'(1 << k);
            end
        end
    endtask

    task automatic check_comb(input string tag);
        logic [4:0]  es, ef;
        logic        ev;
        logic [31:0] ep;
        model_outs(es, ef, ev, ep);
        chk({tag, ".stall"}, 32'(stall_o), 32'(es));
        chk({tag, ".flush"}, 32'(flush_o), 32'(ef));
        chk({tag, ".npc_vld"}, 32'(new_pc_valid_o), 32'(ev));
        chk({tag, ".npc"}, new_pc_o, ep);
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at the edge, check the counter after it.
    task automatic tick(input string tag);
        logic [4:0]  es, ef;
        logic        ev;
        logic [31:0] ep;
        @(negedge clk_i);
        check_comb(tag);
        model_outs(es, ef, ev, ep);
        @(posedge clk_i);
        if (rst_i) begin
            m_pend = 1'b0; m_tgt = '0; m_cnt = 0;
        end else begin
            if (perf_clr_i) m_cnt = 0;
            else if (es[0] && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_pend) begin
                if (!mem_stall_req_i) m_pend = 1'b0;
            end else if (exc_valid_i && mem_stall_req_i) begin
                m_pend = 1'b1; m_tgt = exc_target_i;
            end
        end
        #1;
        chk({tag, ".cnt"}, 32'(stall_cnt_o), 32'(m_cnt));
    endtask

    task automatic set_req(input logic f, input logic d, input logic e, input logic m);
        if_stall_req_i = f; id_stall_req_i = d; ex_stall_req_i = e; mem_stall_req_i = m;
    endtask

    initial begin
        rst_i = 1'b1;
        set_req(1, 1, 1, 1);
        exc_valid_i = 1'b1; exc_target_i = 32'hDEADBEEF; perf_clr_i = 1'b0;

        // Outputs forced low while reset is held, whatever the requests say.
        #2;
        check_comb("reset_hold");
        chk("reset_cnt", 32'(stall_cnt_o), 32'h0);
        tick("reset_tick");

        set_req(0, 1, 0, 0);
        exc_valid_i = 1'b0;
        rst_i = 1'b0;
        // First cycle after release honours the ID request; counter climbs one per cycle.
        for (int i = 0; i < 3; i++) tick("id_only");
        chk("id_cnt3", 32'(stall_cnt_o), 32'd3);

        set_req(1, 0, 0, 0); tick("if_only");
        set_req(0, 0, 1, 0); tick("ex_only");
        set_req(1, 1, 1, 1); tick("all_req");
        set_req(0, 0, 0, 0); tick("idle");

        // Exception with no MEM stall redirects at once and overrides the EX stall.
        set_req(0, 0, 1, 0);
        exc_valid_i = 1'b1; exc_target_i = 32'hBFC00380;
        tick("exc_now");

        // Exception behind a 3-cycle MEM stall; later exc inputs are ignored while waiting.
        set_req(0, 0, 0, 1);
        exc_target_i = 32'h80000180;
        tick("exc_wait0");
        exc_target_i = 32'h12345678;
        tick("exc_wait1");
        exc_valid_i = 1'b0;
        tick("exc_wait2");
        set_req(0, 0, 0, 0);
        tick("exc_redirect");
        chk("exc_redirect_pc", m_tgt, 32'h80000180);
        tick("exc_back_run");

        // Randomized mix, with occasional exceptions and counter clears.
        for (int i = 0; i < 400; i++) begin
            set_req(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
            exc_valid_i  = 1'($urandom_range(0, 7) == 0);
            exc_target_i = $urandom;
            perf_clr_i   = 1'($urandom_range(0, 31) == 0);
            tick("rand");
        end
        set_req(0, 0, 0, 0); exc_valid_i = 1'b0; perf_clr_i = 1'b0;
        tick("rand_drain");
        tick("rand_drain");

        // Reset asserted mid-cycle while an exception waits on MEM: outputs drop at once, no redirect later.
        set_req(0, 0, 0, 1);
        exc_valid_i = 1'b1; exc_target_i = 32'hCAFE0000;
        tick("pre_rst_wait");
        exc_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        m_pend = 1'b0; m_tgt = '0; m_cnt = 0;
        check_comb("rst_in_wait");
        chk("rst_in_wait_cnt", 32'(stall_cnt_o), 32'h0);
        tick("rst_in_wait_hold");
        rst_i = 1'b0;
        set_req(0, 0, 0, 0);
        tick("post_rst0");
        tick("post_rst1");

        // Saturation after a long MEM stall, then a clear with the stall still active.
        set_req(0, 0, 0, 1);
        for (int i = 0; i < 70000; i++) tick("long_stall");
        chk("sat_cnt", 32'(stall_cnt_o), 32'h0000FFFF);
        perf_clr_i = 1'b1;
        tick("clr_over_inc");
        chk("clr_cnt", 32'(stall_cnt_o), 32'h0);
        perf_clr_i = 1'b0;
        tick("resume");
        chk("resume_cnt", 32'(stall_cnt_o), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port if_stall_req_i, input, 1, IF not ready (icache miss).
REQ-004 SHALL have port id_stall_req_i, input, 1, ID hazard (load-use).
REQ-005 SHALL have port ex_stall_req_i, input, 1, EX multi-cycle op busy (mult/div).
REQ-006 SHALL have port mem_stall_req_i, input, 1, MEM not ready (dcache miss).
REQ-007 SHALL have port exc_valid_i, input, 1, exception committed by the instruction in MEM.
REQ-008 SHALL have port exc_target_i, input, 32, exception handler address.
REQ-009 SHALL have port perf_clr_i, input, 1, synchronous clear of the stall counter.
REQ-010 SHALL have port stall_o, output, 5, hold enables: bit0 PC, bit1 IF2ID, bit2 ID2EX, bit3 EX2MEM, bit4 MEM2WB.
REQ-011 SHALL have port flush_o, output, 5, bubble/clear enables, same bit mapping; bit0 always 0.
REQ-012 SHALL have port new_pc_valid_o, output, 1, redirect PC this cycle.
REQ-013 SHALL have port new_pc_o, output, 32, redirect address; 0 when new_pc_valid_o is 0.
REQ-014 SHALL have port stall_cnt_o, output, 16, count of cycles with stall_o[0]=1.

Function
REQ-015 SHALL implement FSM states RUN and WAIT_MEM; stall_o, flush_o, new_pc_valid_o and new_pc_o are combinational from state and inputs (same-cycle effect).
REQ-016 SHALL, in RUN without exception, select the latest requesting stage, priority MEM > EX > ID > IF.
REQ-017 SHALL produce: MEM req -> stall_o=01111, flush_o=10000; EX req -> 00111, 01000; ID req -> 00011, 00100; IF req -> 00001, 00010; none -> 00000, 00000.
REQ-018 SHALL, in RUN with exc_valid_i=1 and mem_stall_req_i=0, drive flush_o=11110, stall_o=00000, new_pc_valid_o=1, new_pc_o=exc_target_i in that cycle, ignore all stall requests, and remain in RUN.
REQ-019 SHALL, in RUN with exc_valid_i=1 and mem_stall_req_i=1, drive the MEM stall pattern, latch exc_target_i into a 32-bit register, and move to WAIT_MEM.
REQ-020 SHALL, in WAIT_MEM while mem_stall_req_i=1, drive stall_o=01111, flush_o=10000 and ignore exc_valid_i and exc_target_i.
REQ-021 SHALL, in WAIT_MEM when mem_stall_req_i=0, drive flush_o=11110, stall_o=00000, new_pc_valid_o=1, new_pc_o=latched target, and return to RUN next cycle.
REQ-022 SHALL increment stall_cnt_o on each rising edge where stall_o[0]=1, saturating at 16'hFFFF.
REQ-023 SHALL give perf_clr_i priority over increment: clear to 0 on that edge.

Reset
REQ-024 SHALL, while rst_i=1, asynchronously force state=RUN, latched target=0, stall_cnt_o=0, and drive stall_o=0, flush_o=0, new_pc_valid_o=0, new_pc_o=0.
REQ-025 SHALL, on rst_i asserted in WAIT_MEM, discard the pending exception; no redirect after release.
REQ-026 SHALL reach RUN on the first edge after rst_i deasserts and honour requests from that cycle.

Verification
REQ-027 SHALL cover: id_stall_req_i=1 alone -> stall_o=00011, flush_o=00100; stall_cnt_o +1 per cycle.
REQ-028 SHALL cover: if, id, ex and mem requests all 1 -> stall_o=01111, flush_o=10000.
REQ-029 SHALL cover: exc_valid_i=1, exc_target_i=32'hBFC00380, ex_stall_req_i=1 -> same cycle flush_o=11110, stall_o=0, new_pc_o=32'hBFC00380, new_pc_valid_o=1.
REQ-030 SHALL cover: exc_valid_i=1, target 32'h80000180, mem_stall_req_i=1 for 3 cycles -> MEM stall pattern for 3 cycles, then 1 redirect cycle to 32'h80000180, then RUN.
REQ-031 SHALL cover: stall held 70000 cycles -> stall_cnt_o=16'hFFFF; perf_clr_i pulse with stall still active -> 0, then resumes counting.
REQ-032 SHALL cover: rst_i pulsed during WAIT_MEM -> outputs 0 immediately; no new_pc_valid_o after release.
